// File: rtl/mips_bp_if.sv
// Fetch/decode side bundle of the branch predictor.
//  master : pipeline side, drives the fetch PC and the decode-stage resolution
//  slave  : predictor side, returns the fetch-stage prediction
//  pcF, predict_*, btb_hit           : zero-latency lookup
//  upd_en, upd_pc, upd_taken,
//  upd_target, upd_mispred           : one resolved branch per cycle
interface mips_bp_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pcF;
  logic            predict_taken;
  logic [PC_W-1:0] predict_target;
  logic            btb_hit;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_mispred;

  modport master (
    output pcF, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
    input  predict_taken, predict_target, btb_hit
  );

  modport slave (
    input  pcF, upd_en, upd_pc, upd_taken, upd_target, upd_mispred,
    output predict_taken, predict_target, btb_hit
  );
endinterface

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB plus saturating-counter PHT, bimodal or gshare indexed.
//  clk, reset (async, active low), clear (sync table/history invalidate)
//  bp            : lookup + update bundle (mips_bp_if.slave)
//  ghr_out       : global history (stays 0 in bimodal mode)
//  stat_branches : resolved branches seen, saturating
//  stat_mispred  : mispredicted branches seen, saturating
module mips_branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int MODE    = 0,
  parameter int PC_W    = 32,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int TAG_W  = PC_W - IDX_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  mips_bp_if.slave         bp,
  output logic [IDX_W-1:0] ghr_out,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [PC_W-1:0]    target [ENTRIES];
  logic [CTR_W-1:0]   ctr    [ENTRIES];
  logic [IDX_W-1:0]   ghr;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic [IDX_W:0]   ghr_shift;

  // ghr is held at 0 in bimodal mode, so the XOR degenerates to plain pc bits
  assign lk_idx    = bp.pcF[IDX_W+1:2] ^ ghr;
  assign up_idx    = bp.upd_pc[IDX_W+1:2] ^ ghr;
  assign lk_tag    = bp.pcF[PC_W-1:IDX_W+2];
  assign up_tag    = bp.upd_pc[PC_W-1:IDX_W+2];
  // widened by one bit so the shift also works for IDX_W == 1
  assign ghr_shift = {ghr, bp.upd_taken};

  assign bp.btb_hit        = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign bp.predict_taken  = bp.btb_hit && ctr[lk_idx][CTR_W-1];
  assign bp.predict_target = bp.btb_hit ? target[lk_idx] : bp.pcF + PC_W'(4);
  assign ghr_out           = ghr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      ghr   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= CTR_INIT;
      end
    end else if (clear) begin
      // tags/targets are don't-care once valid drops
      valid <= '0;
      ghr   <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    end else if (bp.upd_en) begin
      if (bp.upd_taken) begin
        if (ctr[up_idx] != CTR_MAX) ctr[up_idx] <= ctr[up_idx] + 1'b1;
        valid[up_idx]  <= 1'b1;
        tag[up_idx]    <= up_tag;
        target[up_idx] <= bp.upd_target;
      end else if (ctr[up_idx] != '0) begin
        ctr[up_idx] <= ctr[up_idx] - 1'b1;
      end
      if (MODE != 0) ghr <= ghr_shift[IDX_W-1:0];
    end
  end

  // statistics survive clear; only reset zeroes them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (bp.upd_en) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
      if (bp.upd_mispred && stat_mispred != '1) stat_mispred <= stat_mispred + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_branch_predictor.sv
module tb_mips_branch_predictor;
  logic        clk = 0;
  logic        reset = 0;
  logic        clear = 0;
  logic [31:0] pcF = 32'h40;
  logic        upd_en = 0, upd_taken = 0, upd_mispred = 0;
  logic [31:0] upd_pc = 0, upd_target = 0;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  mips_bp_if #(.PC_W(32)) bp0 ();
  mips_bp_if #(.PC_W(32)) bp1 ();
  assign bp0.pcF = pcF;          assign bp1.pcF = pcF;
  assign bp0.upd_en = upd_en;    assign bp1.upd_en = upd_en;
  assign bp0.upd_pc = upd_pc;    assign bp1.upd_pc = upd_pc;
  assign bp0.upd_taken = upd_taken;     assign bp1.upd_taken = upd_taken;
  assign bp0.upd_target = upd_target;   assign bp1.upd_target = upd_target;
  assign bp0.upd_mispred = upd_mispred; assign bp1.upd_mispred = upd_mispred;

  logic [3:0]  ghr_o [2];
  logic [31:0] sb_o [2], sm_o [2];

  mips_branch_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(0), .PC_W(32)) u0 (
    .clk(clk), .reset(reset), .clear(clear), .bp(bp0),
    .ghr_out(ghr_o[0]), .stat_branches(sb_o[0]), .stat_mispred(sm_o[0]));
  mips_branch_predictor #(.ENTRIES(16), .CTR_W(2), .MODE(1), .PC_W(32)) u1 (
    .clk(clk), .reset(reset), .clear(clear), .bp(bp1),
    .ghr_out(ghr_o[1]), .stat_branches(sb_o[1]), .stat_mispred(sm_o[1]));

  logic        hit_o [2], tk_o [2];
  logic [31:0] tgt_o [2];
  assign hit_o[0] = bp0.btb_hit; assign tk_o[0] = bp0.predict_taken; assign tgt_o[0] = bp0.predict_target;
  assign hit_o[1] = bp1.btb_hit; assign tk_o[1] = bp1.predict_taken; assign tgt_o[1] = bp1.predict_target;

  // ---------------- behavioural model: [0]=bimodal, [1]=gshare ----------------
  bit          m_vld [2][16];
  logic [31:0] m_pc  [2][16];   // full PC of the allocating branch; tag = pc >> 6
  logic [31:0] m_tgt [2][16];
  int          m_ctr [2][16];
  int          m_ghr [2];
  longint      m_sb, m_sm;

  function automatic int idx_of(int m, logic [31:0] pc);
    return ((pc >> 2) ^ (m == 1 ? m_ghr[1] : 0)) % 16;
  endfunction

  task automatic model_tables_init();
    for (int m = 0; m < 2; m++) begin
      m_ghr[m] = 0;
      for (int i = 0; i < 16; i++) begin
        m_vld[m][i] = 0; m_ctr[m][i] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_tables_init();
      m_sb = 0; m_sm = 0;
    end else begin
      if (upd_en) begin
        if (m_sb < 64'hFFFF_FFFF) m_sb++;
        if (upd_mispred && m_sm < 64'hFFFF_FFFF) m_sm++;
      end
      if (clear) model_tables_init();
      else if (upd_en) begin
        for (int m = 0; m < 2; m++) begin
          int i;
          i = idx_of(m, upd_pc);
          if (upd_taken) begin
            m_ctr[m][i] = (m_ctr[m][i] < 3) ? m_ctr[m][i] + 1 : 3;
            m_vld[m][i] = 1; m_pc[m][i] = upd_pc; m_tgt[m][i] = upd_target;
          end else begin
            m_ctr[m][i] = (m_ctr[m][i] > 0) ? m_ctr[m][i] - 1 : 0;
          end
          if (m == 1) m_ghr[1] = ((m_ghr[1] << 1) | int'(upd_taken)) % 16;
        end
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int  i;
      bit  h;
      i = idx_of(m, pcF);
      h = m_vld[m][i] && ((m_pc[m][i] >> 6) == (pcF >> 6));
      chk($sformatf("hit[%0d] pc=%0h", m, pcF), 64'(hit_o[m]), 64'(h));
      chk($sformatf("taken[%0d] pc=%0h", m, pcF), 64'(tk_o[m]), 64'(h && m_ctr[m][i] >= 2));
      chk($sformatf("target[%0d] pc=%0h", m, pcF), 64'(tgt_o[m]), 64'(h ? m_tgt[m][i] : pcF + 4));
      chk($sformatf("ghr[%0d]", m), 64'(ghr_o[m]), 64'(m_ghr[m]));
      chk($sformatf("stat_br[%0d]", m), 64'(sb_o[m]), 64'(m_sb));
      chk($sformatf("stat_mp[%0d]", m), 64'(sm_o[m]), 64'(m_sm));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_upd(logic [31:0] pc, logic tk, logic [31:0] tg, logic mp);
    upd_en = 1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispred = mp;
    tick();
    upd_en = 0;
  endtask

  initial begin
    // reset state
    sample();
    chk("rst hit", 64'(bp0.btb_hit), 0);
    chk("rst taken", 64'(bp0.predict_taken), 0);
    chk("rst target", 64'(bp0.predict_target), 64'h44);
    chk("rst stat", 64'(sb_o[0]), 0);
    tick(); reset = 1;

    // first taken allocation
    do_upd(32'h40, 1, 32'h20, 1);
    sample();
    chk("t2 hit", 64'(bp0.btb_hit), 1);
    chk("t2 taken", 64'(bp0.predict_taken), 1);
    chk("t2 target", 64'(bp0.predict_target), 64'h20);
    tick();

    // decrement to 0 and saturate
    repeat (3) do_upd(32'h40, 0, 32'h0, 1);
    sample();
    chk("t3 hit", 64'(bp0.btb_hit), 1);
    chk("t3 taken", 64'(bp0.predict_taken), 0);
    tick();

    // saturate at 3, one not-taken still predicts taken
    repeat (5) do_upd(32'h40, 1, 32'h20, 0);
    do_upd(32'h40, 0, 32'h0, 0);
    sample();
    chk("t4 taken", 64'(bp0.predict_taken), 1);
    tick();

    // aliasing at index 0
    do_upd(32'h80, 1, 32'h100, 0);
    sample();
    chk("t5 hit", 64'(bp0.btb_hit), 0);
    chk("t5 target", 64'(bp0.predict_target), 64'h44);
    tick();
    pcF = 32'h80;
    sample();
    chk("t5 hit80", 64'(bp0.btb_hit), 1);
    chk("t5 tgt80", 64'(bp0.predict_target), 64'h100);
    tick();

    // clear with a simultaneous update: tables cleared, stats still count
    clear = 1;
    do_upd(32'h80, 1, 32'h100, 0);
    clear = 0;
    sample();
    chk("clr hit", 64'(bp0.btb_hit), 0);
    chk("clr ghr", 64'(ghr_o[1]), 0);
    tick();

    // gshare history
    do_upd(32'h200, 1, 32'h10, 0);
    do_upd(32'h200, 1, 32'h10, 0);
    do_upd(32'h200, 0, 32'h10, 0);
    sample();
    chk("t6 ghr", 64'(ghr_o[1]), 64'h6);
    chk("t6 ghr bimodal", 64'(ghr_o[0]), 0);
    tick();

    // same-cycle lookup and update of the same index
    pcF = 32'h300;
    upd_en = 1; upd_pc = 32'h300; upd_taken = 1; upd_target = 32'h1234; upd_mispred = 0;
    sample();
    chk("same old hit", 64'(bp0.btb_hit), 0);
    tick(); upd_en = 0;
    sample();
    chk("same new hit", 64'(bp0.btb_hit), 1);
    chk("same new tgt", 64'(bp0.predict_target), 64'h1234);
    chk("stat branches", 64'(sb_o[0]), 16);
    chk("stat mispred", 64'(sm_o[0]), 4);
    tick();

    // randomized traffic, with one asynchronous reset pulse mid-run
    for (int c = 0; c < 3000; c++) begin
      pcF         = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      upd_en      = ($urandom_range(0, 9) < 6);
      upd_pc      = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 15) == 0) upd_pc[31:28] = 4'($urandom_range(1, 15));
      upd_taken   = 1'($urandom_range(0, 1));
      upd_target  = $urandom & 32'hFFFF_FFFC;
      upd_mispred = 1'($urandom_range(0, 1));
      clear       = ($urandom_range(0, 199) == 0);
      if (c == 1500) begin
        #2 reset = 0;
        #4 reset = 1;
        @(posedge clk); #1;
      end else begin
        tick();
      end
    end
    upd_en = 0; clear = 0;
    tick();
    sample();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
